i2s_clk_ctrl: RTL and testbench

- Master-mode clock and sample sequencer for the `i2s_tx` serializer.
- Divides the system clock into `sck_o` and `ws_o`, accepts stereo sample pairs over a valid/ready handshake, and presents them on `l_data_o`/`r_data_o`. Updates are timed so the serializer never latches a half-updated word.
- Handles start/stop at frame boundaries and reports buffer underruns.

---
 rtl/i2s_clk_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_i2s_clk_ctrl.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_clk_ctrl.sv
// i2s_clk_ctrl: master-mode bit/word clock generator and stereo sample
// sequencer for the i2s_tx serializer. It holds one L/R pair, loads the left
// word at each ws rise and the right word at each ws fall, so neither data
// output changes while the serializer is shifting it.
module i2s_clk_ctrl #(
    parameter int unsigned AUDIO_DW = 8,
    parameter int unsigned SCK_DIV  = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                s_valid_i,
    input  logic [AUDIO_DW-1:0] s_l_i,
    input  logic [AUDIO_DW-1:0] s_r_i,
    output logic                s_ready_o,
    output logic                sck_o,
    output logic                ws_o,
    output logic [AUDIO_DW-1:0] l_data_o,
    output logic [AUDIO_DW-1:0] r_data_o,
    output logic                busy_o,
    output logic                underrun_o,
    output logic [7:0]          underrun_cnt_o
);

    localparam int unsigned DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(AUDIO_DW);
    localparam int unsigned CNT_W = 8;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(AUDIO_DW - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e              state_q;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                sck_q;
    logic                ws_q;
    logic                busy_q;
    logic                ready_q;
    logic [AUDIO_DW-1:0] hold_l_q, hold_r_q;
    logic [AUDIO_DW-1:0] r_pend_q;
    logic [AUDIO_DW-1:0] l_data_q, r_data_q;
    logic                underrun_q;
    logic [CNT_W-1:0]    underrun_cnt_q;

    logic                active_c, sck_tick_c, sck_fall_c;
    logic                ws_tgl_c, ws_rise_c, ws_fall_c;
    logic                start_load_c, drain_end_c;
    logic                l_upd_c, r_upd_c, consume_c, xfer_c;
    logic [AUDIO_DW-1:0] pend_l_c, pend_r_c;

    // Event decode: divider terminal count, sck falling edge, word boundary.
    assign active_c     = (state_q != ST_IDLE);
    assign sck_tick_c   = active_c && (div_cnt_q == DIV_LAST);
    assign sck_fall_c   = sck_tick_c && sck_q;
    assign ws_tgl_c     = sck_fall_c && (bit_cnt_q == BIT_LAST);
    assign ws_rise_c    = ws_tgl_c && !ws_q;
    assign ws_fall_c    = ws_tgl_c && ws_q;
    assign start_load_c = (state_q == ST_IDLE) && en_i;
    assign drain_end_c  = (state_q == ST_DRAIN) && ws_fall_c && !en_i;
    assign l_upd_c      = start_load_c || ws_rise_c;
    assign r_upd_c      = start_load_c || (ws_fall_c && !drain_end_c);
    assign consume_c    = l_upd_c && !ready_q;
    assign xfer_c       = s_valid_i && ready_q;
    assign pend_l_c     = ready_q ? '0 : hold_l_q;
    assign pend_r_c     = ready_q ? '0 : hold_r_q;

    // Free-running divider and bit counter next values.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        bit_cnt_d = bit_cnt_q;
        if (sck_tick_c) begin
            div_cnt_d = '0;
        end
        if (sck_fall_c) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
        end
    end

    // Run/drain sequencing and clock outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            sck_q     <= 1'b0;
            ws_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    div_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    sck_q     <= 1'b0;
                    ws_q      <= 1'b0;
                    if (en_i) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    div_cnt_q <= div_cnt_d;
                    bit_cnt_q <= bit_cnt_d;
                    sck_q     <= sck_q ^ sck_tick_c;
                    ws_q      <= ws_q ^ ws_tgl_c;
                    if (!en_i) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_end_c) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        div_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        sck_q     <= 1'b0;
                        ws_q      <= 1'b0;
                    end else begin
                        div_cnt_q <= div_cnt_d;
                        bit_cnt_q <= bit_cnt_d;
                        sck_q     <= sck_q ^ sck_tick_c;
                        ws_q      <= ws_q ^ ws_tgl_c;
                        if (en_i) begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Holding register, word loads and underrun accounting.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ready_q        <= 1'b1;
            hold_l_q       <= '0;
            hold_r_q       <= '0;
            r_pend_q       <= '0;
            l_data_q       <= '0;
            r_data_q       <= '0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            underrun_q <= 1'b0;
            if (consume_c) begin
                ready_q <= 1'b1;
            end else if (xfer_c) begin
                ready_q  <= 1'b0;
                hold_l_q <= s_l_i;
                hold_r_q <= s_r_i;
            end
            if (l_upd_c) begin
                l_data_q <= pend_l_c;
                r_pend_q <= pend_r_c;
                if (ready_q) begin
                    underrun_q <= 1'b1;
                    if (underrun_cnt_q != '1) begin
                        underrun_cnt_q <= underrun_cnt_q + CNT_W'(1);
                    end
                end
            end
            // The start load forwards the freshly selected right word directly.
            if (r_upd_c) begin
                r_data_q <= start_load_c ? pend_r_c : r_pend_q;
            end
        end
    end

    assign s_ready_o      = ready_q;
    assign sck_o          = sck_q;
    assign ws_o           = ws_q;
    assign l_data_o       = l_data_q;
    assign r_data_o       = r_data_q;
    assign busy_o         = busy_q;
    assign underrun_o     = underrun_q;
    assign underrun_cnt_o = underrun_cnt_q;

endmodule

// File: tb/tb_i2s_clk_ctrl.sv
// tb_i2s_clk_ctrl: three instances (default, DW=2/DIV=1, DW=16/DIV=7) driven by
// shared random stimulus and compared every cycle against a frame-phase model.
module tb_i2s_clk_ctrl;

    localparam logic [44:0] RESET_VEC = {1'b1, 44'd0};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] sl = '0;
    logic [15:0] sr = '0;

    logic rdy0, sck0, ws0, busy0, und0;
    logic [7:0] l0, r0, cnt0;
    logic rdy1, sck1, ws1, busy1, und1;
    logic [1:0] l1, r1;
    logic [7:0] cnt1;
    logic rdy2, sck2, ws2, busy2, und2;
    logic [15:0] l2, r2;
    logic [7:0] cnt2;

    int checks = 0;
    int errors = 0;

    // Per-instance parameters and model state.
    int          D [3]  = '{4, 1, 7};
    int          DW [3] = '{8, 2, 16};
    bit          m_active [3];
    bit          m_drain [3];
    bit          m_full [3];
    int          p [3];
    logic [15:0] m_hl [3], m_hr [3], m_rp [3], m_l [3], m_r [3];
    bit          m_und [3];
    int          m_cnt [3];

    always #5 clk = ~clk;

    i2s_clk_ctrl #(.AUDIO_DW(8), .SCK_DIV(4)) u0 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .s_valid_i(valid),
        .s_l_i(sl[7:0]), .s_r_i(sr[7:0]), .s_ready_o(rdy0), .sck_o(sck0),
        .ws_o(ws0), .l_data_o(l0), .r_data_o(r0), .busy_o(busy0),
        .underrun_o(und0), .underrun_cnt_o(cnt0)
    );

    i2s_clk_ctrl #(.AUDIO_DW(2), .SCK_DIV(1)) u1 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .s_valid_i(valid),
        .s_l_i(sl[1:0]), .s_r_i(sr[1:0]), .s_ready_o(rdy1), .sck_o(sck1),
        .ws_o(ws1), .l_data_o(l1), .r_data_o(r1), .busy_o(busy1),
        .underrun_o(und1), .underrun_cnt_o(cnt1)
    );

    i2s_clk_ctrl #(.AUDIO_DW(16), .SCK_DIV(7)) u2 (
        .clk_i(clk), .rst_i(rst), .en_i(en), .s_valid_i(valid),
        .s_l_i(sl), .s_r_i(sr), .s_ready_o(rdy2), .sck_o(sck2),
        .ws_o(ws2), .l_data_o(l2), .r_data_o(r2), .busy_o(busy2),
        .underrun_o(und2), .underrun_cnt_o(cnt2)
    );

    // Observed outputs packed as {ready, sck, ws, busy, underrun, l, r, cnt}.
    function automatic logic [44:0] obs_vec(input int i);
        case (i)
            0:       return {rdy0, sck0, ws0, busy0, und0, 16'(l0), 16'(r0), cnt0};
            1:       return {rdy1, sck1, ws1, busy1, und1, 16'(l1), 16'(r1), cnt1};
            default: return {rdy2, sck2, ws2, busy2, und2, l2, r2, cnt2};
        endcase
    endfunction

    // Expected outputs from the model: clocks are pure functions of frame phase.
    function automatic logic [44:0] exp_vec(input int i);
        logic s, w;
        s = m_active[i] ? 1'((p[i] / D[i]) % 2) : 1'b0;
        w = m_active[i] ? 1'((p[i] / (2 * DW[i] * D[i])) % 2) : 1'b0;
        return {!m_full[i], s, w, m_active[i], m_und[i], m_l[i], m_r[i], 8'(m_cnt[i])};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_active[i] = 0; m_drain[i] = 0; m_full[i] = 0; p[i] = 0;
            m_hl[i] = '0; m_hr[i] = '0; m_rp[i] = '0; m_l[i] = '0; m_r[i] = '0;
            m_und[i] = 0; m_cnt[i] = 0;
        end
    endtask

    // Left word load: take the held pair or substitute silence and count an underrun.
    task automatic l_update(input int i);
        if (m_full[i]) begin
            m_l[i] = m_hl[i]; m_rp[i] = m_hr[i]; m_full[i] = 0;
        end else begin
            m_l[i] = '0; m_rp[i] = '0; m_und[i] = 1;
            if (m_cnt[i] < 255) m_cnt[i]++;
        end
    endtask

    // Model of one rising edge, using phase p within a frame of 4*DW*D cycles.
    task automatic model_edge(input int i);
        int f;
        logic [15:0] msk;
        bit hs;
        f   = 4 * DW[i] * D[i];
        msk = 16'((32'd1 << DW[i]) - 1);
        hs  = valid && !m_full[i];
        m_und[i] = 0;
        if (!m_active[i]) begin
            if (en) begin
                l_update(i);
                m_r[i] = m_rp[i];
                m_active[i] = 1; m_drain[i] = 0; p[i] = 0;
            end
        end else if (p[i] + 1 == f && m_drain[i] && !en) begin
            m_active[i] = 0; p[i] = 0;
        end else begin
            p[i] = (p[i] + 1) % f;
            if (p[i] == f / 2) l_update(i);
            if (p[i] == 0) m_r[i] = m_rp[i];
            m_drain[i] = !en;
        end
        if (hs) begin
            m_full[i] = 1; m_hl[i] = sl & msk; m_hr[i] = sr & msk;
        end
    endtask

    // Advance one clock: DUT and model see the same inputs; returns 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else for (int i = 0; i < 3; i++) model_edge(i);
        #1;
    endtask

    task automatic test_reset();
        en = 1; valid = 1; sl = 16'h5a5a; sr = 16'hc3c3; rst = 1;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_vec(i) !== RESET_VEC) begin
                errors++; $display("FAIL reset inst%0d got %h want %h", i, obs_vec(i), RESET_VEC);
            end
        end
        rst = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
                errors++; $display("FAIL start_load inst%0d got %h want %h", i, obs_vec(i), exp_vec(i));
            end
        end
        checks++;
        if (und0 !== 1'b1 || cnt0 !== 8'd1 || busy0 !== 1'b1) begin
            errors++; $display("FAIL start_underrun und=%b cnt=%0d busy=%b want 1 1 1", und0, cnt0, busy0);
        end
    endtask

    task automatic test_clock_shape();
        int run, last_t;
        bit first;
        logic ps, pw;
        run = 0; last_t = -1; first = 1; ps = sck0; pw = ws0;
        en = 1;
        for (int n = 0; n < 384; n++) begin
            valid = 1'($urandom_range(0, 1)); sl = 16'($urandom); sr = 16'($urandom);
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL clock_model inst%0d got %h want %h", i, obs_vec(i), exp_vec(i));
                end
            end
            if (sck0 == ps) run++;
            else begin
                if (!first) begin
                    checks++;
                    if (run != 4) begin errors++; $display("FAIL sck_half got %0d want 4", run); end
                end
                first = 0; run = 1;
            end
            if (ws0 != pw) begin
                checks++;
                if (!(ps == 1'b1 && sck0 == 1'b0)) begin
                    errors++; $display("FAIL ws_on_fall sck %b->%b want 1->0", ps, sck0);
                end
                if (last_t >= 0) begin
                    checks++;
                    if (n - last_t != 64) begin errors++; $display("FAIL ws_period got %0d want 64", n - last_t); end
                end
                last_t = n;
            end
            ps = sck0; pw = ws0;
        end
    endtask

    task automatic test_streaming();
        logic [7:0] pl [2];
        logic [7:0] pr [2];
        logic [7:0] prev_l, prev_r, l_low;
        logic pw, rdy_pre;
        int idx, rises, nund;
        bit have_l;
        pl[0] = 8'hA5; pl[1] = 8'h11; pr[0] = 8'h3C; pr[1] = 8'hEE;
        en = 1; valid = 1; idx = 0; sl = 16'(pl[0]); sr = 16'(pr[0]);
        pw = ws0; prev_l = l0; prev_r = r0; l_low = '0; rises = 0; nund = 0; have_l = 0;
        for (int n = 0; n < 512; n++) begin
            rdy_pre = rdy0;
            tick();
            if (rdy_pre) begin
                idx ^= 1; sl = 16'(pl[idx]); sr = 16'(pr[idx]);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL stream_model inst%0d got %h want %h", i, obs_vec(i), exp_vec(i));
                end
            end
            if (n >= 2 && und0) nund++;
            if (!pw && ws0) begin
                rises++;
                if (rises >= 3) begin l_low = prev_l; have_l = 1; end
            end
            if (pw && !ws0 && have_l) begin
                checks++;
                if (!((l_low == 8'hA5 && prev_r == 8'h3C) || (l_low == 8'h11 && prev_r == 8'hEE))) begin
                    errors++; $display("FAIL stream_pair l=%h r=%h want A5/3C or 11/EE", l_low, prev_r);
                end
            end
            pw = ws0; prev_l = l0; prev_r = r0;
        end
        checks++;
        if (nund != 0) begin errors++; $display("FAIL stream_underrun got %0d want 0", nund); end
    endtask

    task automatic test_underrun();
        int n, pulses;
        logic pw;
        logic [7:0] c0;
        valid = 1; n = 0; pw = ws0;
        while (n < 200) begin
            tick(); n++;
            if (!pw && ws0) break;
            pw = ws0;
        end
        checks++;
        if (n >= 200) begin errors++; $display("FAIL underrun_wait got timeout want ws rise"); end
        valid = 0; c0 = cnt0; pulses = 0;
        for (int k = 0; k < 256; k++) begin
            tick();
            if (und0) pulses++;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL underrun_model inst%0d got %h want %h", i, obs_vec(i), exp_vec(i));
                end
            end
        end
        checks++;
        if (pulses != 2 || cnt0 !== 8'(c0 + 8'd2)) begin
            errors++; $display("FAIL underrun_count pulses=%0d cnt=%0d want 2 %0d", pulses, cnt0, c0 + 8'd2);
        end
        checks++;
        if (l0 !== 8'd0 || r0 !== 8'd0) begin
            errors++; $display("FAIL underrun_zero l=%h r=%h want 00 00", l0, r0);
        end
        for (int k = 0; k < 2500; k++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL saturate_model inst%0d got %h want %h", i, obs_vec(i), exp_vec(i));
                end
            end
        end
        checks++;
        if (cnt1 !== 8'd255) begin errors++; $display("FAIL saturate got %0d want 255", cnt1); end
    endtask

    task automatic test_stop_restart();
        int n, run;
        logic ps;
        en = 1; n = 0;
        while (!(m_active[0] && p[0] == 20) && n < 400) begin
            valid = 1'($urandom_range(0, 1)); sl = 16'($urandom); sr = 16'($urandom);
            tick(); n++;
        end
        checks++;
        if (n >= 400) begin errors++; $display("FAIL stop_wait got timeout want phase 20"); end
        en = 0; n = 0; run = 1; ps = sck0;
        while (busy0 && n < 300) begin
            tick(); n++;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL drain_model inst%0d got %h want %h", i, obs_vec(i), exp_vec(i));
                end
            end
            if (sck0 == ps) run++;
            else begin
                checks++;
                if (run != 4) begin errors++; $display("FAIL drain_sck_half got %0d want 4", run); end
                run = 1;
            end
            ps = sck0;
        end
        checks++;
        if (n != 108 || sck0 !== 1'b0 || ws0 !== 1'b0) begin
            errors++; $display("FAIL drain_end cycles=%0d sck=%b ws=%b want 108 0 0", n, sck0, ws0);
        end
        repeat (5) tick();
        checks++;
        if (busy0 !== 1'b0 || sck0 !== 1'b0) begin
            errors++; $display("FAIL idle_hold busy=%b sck=%b want 0 0", busy0, sck0);
        end
        en = 1; n = 0;
        while (!(m_active[0] && p[0] == 100) && n < 400) begin tick(); n++; end
        checks++;
        if (n >= 400) begin errors++; $display("FAIL restart_wait got timeout want phase 100"); end
        en = 0; run = 1; ps = sck0;
        for (int k = 0; k < 150; k++) begin
            if (k == 10) en = 1;
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL rearm_model inst%0d got %h want %h", i, obs_vec(i), exp_vec(i));
                end
            end
            checks++;
            if (busy0 !== 1'b1) begin errors++; $display("FAIL rearm_busy got %b want 1", busy0); end
            if (sck0 == ps) run++;
            else begin
                checks++;
                if (run != 4) begin errors++; $display("FAIL rearm_sck_half got %0d want 4", run); end
                run = 1;
            end
            ps = sck0;
        end
    endtask

    task automatic test_param_sweep();
        int last_rise [3];
        logic [44:0] pv [3];
        logic [44:0] cv;
        en = 1;
        for (int i = 0; i < 3; i++) begin last_rise[i] = -1; pv[i] = obs_vec(i); end
        for (int n = 0; n < 1400; n++) begin
            valid = 1'($urandom_range(0, 1)); sl = 16'($urandom); sr = 16'($urandom);
            tick();
            for (int i = 0; i < 3; i++) begin
                cv = obs_vec(i);
                checks++;
                if (cv !== exp_vec(i)) begin
                    errors++; $display("FAIL sweep_model inst%0d got %h want %h", i, cv, exp_vec(i));
                end
                if (!pv[i][42] && cv[42]) begin
                    if (last_rise[i] >= 0) begin
                        checks++;
                        if (n - last_rise[i] != 4 * DW[i] * D[i]) begin
                            errors++; $display("FAIL frame_len inst%0d got %0d want %0d", i, n - last_rise[i], 4 * DW[i] * D[i]);
                        end
                    end
                    last_rise[i] = n;
                end
                if (pv[i][41] && cv[41] && !pv[i][42] && !cv[42]) begin
                    checks++;
                    if (cv[39:24] !== pv[i][39:24]) begin
                        errors++; $display("FAIL l_stable inst%0d got %h want %h", i, cv[39:24], pv[i][39:24]);
                    end
                end
                if (pv[i][41] && cv[41] && pv[i][42] && cv[42]) begin
                    checks++;
                    if (cv[23:8] !== pv[i][23:8]) begin
                        errors++; $display("FAIL r_stable inst%0d got %h want %h", i, cv[23:8], pv[i][23:8]);
                    end
                end
                pv[i] = cv;
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) en = !en;
            valid = 1'($urandom_range(0, 1)); sl = 16'($urandom); sr = 16'($urandom);
            tick();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    errors++; $display("FAIL random_model inst%0d got %h want %h", i, obs_vec(i), exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int n;
        en = 1; valid = 1; n = 0;
        while (!(m_active[0] && p[0] == 50) && n < 400) begin tick(); n++; end
        checks++;
        if (n >= 400) begin errors++; $display("FAIL midreset_wait got timeout want phase 50"); end
        rst = 1;
        #2;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_vec(i) !== RESET_VEC) begin
                errors++; $display("FAIL mid_reset inst%0d got %h want %h", i, obs_vec(i), RESET_VEC);
            end
        end
        model_reset();
        repeat (2) tick();
        en = 0; valid = 0; rst = 0;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_vec(i) !== exp_vec(i)) begin
                errors++; $display("FAIL post_reset inst%0d got %h want %h", i, obs_vec(i), exp_vec(i));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clock_shape();
        test_streaming();
        test_underrun();
        test_stop_restart();
        test_param_sweep();
        test_random();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
